// File: rtl/inter_neuron_scan.sv
// Interneuron between the direction ganglia and the memory neuron array:
// captures one flat sample, scans a descending threshold ladder and writes a shape code per matching rung.
module inter_neuron_scan #(
  parameter int DW      = 7,
  parameter int NTH     = 20,
  parameter int AW      = 5,
  parameter int TH_BASE = 100,
  parameter int TH_STEP = 5,
  parameter int TOL     = 0,
  parameter int CW      = $clog2(NTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [DW-1:0]     flat,
  input  logic              flat_valid,
  output logic              flat_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW+AW-1:0]  wr_data,
  input  logic              wr_ack,
  output logic              done,
  output logic [CW-1:0]     hit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t        state;
  logic [DW-1:0] f_reg;
  logic [AW-1:0] idx;
  logic [DW:0]   th;
  logic [DW:0]   f_ext;
  logic [DW:0]   diff;
  logic          match;
  logic          last;

  // Threshold and distance carry one extra bit so the subtraction never wraps.
  always_comb begin
    th    = (DW+1)'(TH_BASE) - (DW+1)'(int'(idx) * TH_STEP);
    f_ext = {1'b0, f_reg};
    diff  = (f_ext >= th) ? (f_ext - th) : (th - f_ext);
    match = (int'(diff) <= TOL);
    last  = (idx == AW'(NTH - 1));
  end

  assign flat_ready = (state == IDLE) && !mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      f_reg     <= '0;
      idx       <= '0;
      hit_count <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (flat_valid && flat_ready) begin
            f_reg     <= flat;
            idx       <= '0;
            hit_count <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (mode) begin
            state <= IDLE;
          end else if (match) begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= {f_reg, idx};
            state   <= WRITE;
          end else if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        WRITE: begin
          // A hold request only takes effect once the pending write is acknowledged.
          if (wr_ack) begin
            wr_en     <= 1'b0;
            hit_count <= hit_count + CW'(1);
            if (mode) begin
              state <= IDLE;
            end else if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + AW'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inter_neuron_scan.sv
// Bench for inter_neuron_scan: two instances (TOL 0 and TOL 5) share stimulus and are
// checked every cycle against a ladder model built from the threshold rules.
module tb_inter_neuron_scan;
  localparam int DW = 7, NTH = 20, AW = 5, TH_BASE = 100, TH_STEP = 5, CW = 5;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst_n, mode, flat_valid;
  logic [DW-1:0] flat;
  logic ack[NI], wr_en_o[NI], done_o[NI], ready_o[NI];
  logic [AW-1:0] addr_o[NI];
  logic [DW+AW-1:0] data_o[NI];
  logic [CW-1:0] hc_o[NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    inter_neuron_scan #(
      .DW(DW), .NTH(NTH), .AW(AW), .TH_BASE(TH_BASE), .TH_STEP(TH_STEP),
      .TOL(5 * gi), .CW(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .flat(flat), .flat_valid(flat_valid),
      .flat_ready(ready_o[gi]), .wr_en(wr_en_o[gi]), .wr_addr(addr_o[gi]),
      .wr_data(data_o[gi]), .wr_ack(ack[gi]), .done(done_o[gi]), .hit_count(hc_o[gi])
    );
  end

  int total = 0, bad = 0, cyc = 0;

  // Model state: scan running, write outstanding, next rung, last-done pulse, outputs.
  bit m_run[NI], m_wr[NI], m_done[NI];
  int m_pos[NI], m_addr[NI], m_data[NI], m_cnt[NI], m_f[NI];
  bit hitmap[NI][NTH];

  // Observation logs, restarted at each model capture.
  int nwr[NI], wa[NI][16], wd[NI][16], ndone[NI], done_cyc[NI], cap_cyc[NI];
  int cur_run[NI], last_run[NI];
  bit prev_wr[NI];

  bit rand_ack = 1'b0;
  int ack_delay = 0;
  int wcnt[NI];

  function automatic int tol_of(input int g);
    return 5 * g;
  endfunction

  function automatic void chk(input string nm, input int g, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[u%0d] cyc=%0d got=%0d want=%0d", nm, g, cyc, act, exp);
    end
  endfunction

  task automatic advance(input int g);
    if (m_pos[g] == NTH - 1) begin
      m_run[g]  = 1'b0;
      m_done[g] = 1'b1;
    end else begin
      m_pos[g]++;
    end
  endtask

  task automatic model_step(input int g);
    bit was_done;
    if (!rst_n) begin
      m_run[g] = 0; m_wr[g] = 0; m_done[g] = 0; m_pos[g] = 0;
      m_addr[g] = 0; m_data[g] = 0; m_cnt[g] = 0; m_f[g] = 0;
      return;
    end
    was_done  = m_done[g];
    m_done[g] = 1'b0;
    if (m_run[g] && !m_wr[g]) begin
      if (mode) m_run[g] = 1'b0;
      else if (hitmap[g][m_pos[g]]) begin
        m_wr[g]   = 1'b1;
        m_addr[g] = m_pos[g];
        m_data[g] = m_f[g] * (1 << AW) + m_pos[g];
      end else advance(g);
    end else if (m_run[g] && m_wr[g]) begin
      if (ack[g]) begin
        m_wr[g] = 1'b0;
        m_cnt[g]++;
        if (mode) m_run[g] = 1'b0;
        else advance(g);
      end
    end else if (!was_done && !mode && flat_valid) begin
      m_f[g]   = int'(flat);
      m_pos[g] = 0;
      m_cnt[g] = 0;
      m_run[g] = 1'b1;
      for (int i = 0; i < NTH; i++) begin
        int th;
        int d;
        th = TH_BASE - i * TH_STEP;
        d  = (m_f[g] > th) ? (m_f[g] - th) : (th - m_f[g]);
        hitmap[g][i] = (d <= tol_of(g));
      end
      cap_cyc[g] = cyc;
      nwr[g] = 0;
      ndone[g] = 0;
      done_cyc[g] = 0;
    end
  endtask

  // Single compare process: advance the model on the edge, check DUT 2 time units later.
  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < NI; g++) model_step(g);
    #2;
    for (int g = 0; g < NI; g++) begin
      chk("wr_en", g, int'(wr_en_o[g]), int'(m_wr[g]));
      chk("wr_addr", g, int'(addr_o[g]), m_addr[g]);
      chk("wr_data", g, int'(data_o[g]), m_data[g]);
      chk("done", g, int'(done_o[g]), int'(m_done[g]));
      chk("hit_count", g, int'(hc_o[g]), m_cnt[g]);
      chk("flat_ready", g, int'(ready_o[g]), int'(!m_run[g] && !m_done[g] && !mode));
      if (wr_en_o[g] && !prev_wr[g] && nwr[g] < 16) begin
        wa[g][nwr[g]] = int'(addr_o[g]);
        wd[g][nwr[g]] = int'(data_o[g]);
        nwr[g]++;
      end
      prev_wr[g] = wr_en_o[g];
      if (wr_en_o[g]) cur_run[g]++;
      else if (cur_run[g] > 0) begin
        last_run[g] = cur_run[g];
        cur_run[g] = 0;
      end
      if (done_o[g]) begin
        ndone[g]++;
        done_cyc[g] = cyc - cap_cyc[g] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rand_ack) ack[g] = ($urandom_range(0, 2) == 0);
      else ack[g] = wr_en_o[g] && (wcnt[g] >= ack_delay);
      wcnt[g] = wr_en_o[g] ? wcnt[g] + 1 : 0;
    end
  end

  function automatic bit all_idle();
    return !m_run[0] && !m_done[0] && !m_run[1] && !m_done[1];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_idle() && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 0, 1);
  endtask

  task automatic start(input int fv);
    wait_idle();
    flat = DW'(fv);
    flat_valid = 1'b1;
    @(negedge clk);
    flat_valid = 1'b0;
  endtask

  task automatic do_scan(input int fv, input int dly);
    ack_delay = dly;
    start(fv);
    wait_idle();
  endtask

  function automatic int hit_sum(input int g);
    int s = 0;
    for (int i = 0; i < NTH; i++) s += int'(hitmap[g][i]);
    return s;
  endfunction

  initial begin
    int n;
    int v;
    rst_n = 1'b0; mode = 1'b0; flat = '0; flat_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_wr_en", g, int'(wr_en_o[g]), 0);
      chk("rst_done", g, int'(done_o[g]), 0);
      chk("rst_hit_count", g, int'(hc_o[g]), 0);
      chk("rst_flat_ready", g, int'(ready_o[g]), 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    do_scan(60, 0);
    chk("m60_hit8", 0, int'(hitmap[0][8]), 1);
    chk("m60_hits", 0, hit_sum(0), 1);
    chk("m60_hits", 1, hit_sum(1), 3);
    chk("f60_nwr", 0, nwr[0], 1);
    chk("f60_addr", 0, wa[0][0], 8);
    chk("f60_data", 0, wd[0][0], 1928);
    chk("f60_done_cyc", 0, done_cyc[0], 22);
    chk("f60_ndone", 0, ndone[0], 1);
    chk("f60_hc", 0, int'(hc_o[0]), 1);
    chk("f60_addr0", 1, wa[1][0], 7);
    chk("f60_addr2", 1, wa[1][2], 9);
    chk("f60_hc", 1, int'(hc_o[1]), 3);

    do_scan(62, 0);
    chk("f62_nwr", 0, nwr[0], 0);
    chk("f62_done_cyc", 0, done_cyc[0], 21);
    chk("f62_hc", 0, int'(hc_o[0]), 0);
    chk("f62_nwr", 1, nwr[1], 2);
    chk("f62_addr0", 1, wa[1][0], 7);
    chk("f62_data0", 1, wd[1][0], 1991);
    chk("f62_addr1", 1, wa[1][1], 8);
    chk("f62_data1", 1, wd[1][1], 1992);
    chk("f62_hc", 1, int'(hc_o[1]), 2);

    do_scan(100, 0);
    chk("f100_nwr", 0, nwr[0], 1);
    chk("f100_addr", 0, wa[0][0], 0);
    chk("f100_data", 0, wd[0][0], 3200);

    do_scan(0, 0);
    chk("f0_nwr", 0, nwr[0], 0);
    chk("f0_ndone", 0, ndone[0], 1);

    do_scan(60, 3);
    chk("dly_run", 0, last_run[0], 4);
    chk("dly_done_cyc", 0, done_cyc[0], 25);
    chk("dly_addr", 0, wa[0][0], 8);

    // Hold raised while rung 4 is evaluated.
    ack_delay = 0;
    start(60);
    repeat (4) @(negedge clk);
    mode = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) chk("hold_ready", g, int'(ready_o[g]), 0);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_nwr", 0, nwr[0], 0);
    chk("abort_ndone", 0, ndone[0], 0);
    chk("abort_ready", 0, int'(ready_o[0]), 1);

    // Hold raised during the addr-8 write.
    ack_delay = 3;
    start(60);
    n = 0;
    while (!wr_en_o[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wr_wait", 0, int'(wr_en_o[0]), 1);
    mode = 1'b1;
    n = 0;
    while (m_run[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("wabort_nwr", 0, nwr[0], 1);
    chk("wabort_addr", 0, wa[0][0], 8);
    chk("wabort_ndone", 0, ndone[0], 0);
    chk("wabort_hc", 0, int'(hc_o[0]), 1);
    mode = 1'b0;

    // Reset pulse mid-scan.
    ack_delay = 0;
    start(60);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_wr_en", 0, int'(wr_en_o[0]), 0);
    chk("mrst_ready", 0, int'(ready_o[0]), 1);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("mrst_nwr", 0, nwr[0], 0);
    chk("mrst_ndone", 0, ndone[0], 0);

    // Randomized traffic.
    rand_ack = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      mode = ($urandom_range(0, 11) == 0);
      flat_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        v = TH_BASE - int'($urandom_range(0, NTH - 1)) * TH_STEP + int'($urandom_range(0, 12)) - 6;
        if (v < 0) v = 0;
        if (v > 127) v = 127;
        flat = DW'(v);
      end else begin
        flat = DW'($urandom);
      end
    end
    rst_n = 1'b1; mode = 1'b0; flat_valid = 1'b0; rand_ack = 1'b0;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
